// File: rtl/fifo_uart_rd_ctrl_pkg.sv
// Shared definitions for the FIFO-to-UART read scheduler: FSM states,
// default sizing and a constant-foldable ceil-log2 helper.
package fifo_uart_rd_ctrl_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_BYTE_CYCLES = 320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_e;

    function automatic int unsigned ctrl_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_uart_rd_ctrl_if.sv
// FIFO read port plus uart_tx start handshake, bundled for the read scheduler.
interface fifo_uart_rd_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;

    modport master (
        input  fifo_empty, fifo_dout, tx_busy,
        output fifo_rd_en, tx_start, tx_data
    );

    modport slave (
        output fifo_empty, fifo_dout, tx_busy,
        input  fifo_rd_en, tx_start, tx_data
    );
endinterface

// File: rtl/fifo_uart_rd_ctrl_gap_timer.sv
// Inter-frame gap counter: loadable, counts down to zero and parks there.
module uart_gap_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/fifo_uart_rd_ctrl.sv
// Pops one byte per UART frame from the packing FIFO and hands it to uart_tx,
// holding off the next pop until the minimum frame period has elapsed.
module fifo_uart_rd_ctrl
    import fifo_uart_rd_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned BYTE_CYCLES = DEF_BYTE_CYCLES,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    byte_cnt,
    output logic                busy,
    fifo_uart_rd_ctrl_if.master bus
);
    localparam int unsigned GAP_W      = ctrl_clog2(BYTE_CYCLES);
    localparam int unsigned WAIT_W_RAW = ctrl_clog2(RD_LATENCY);
    localparam int unsigned WAIT_W     = (WAIT_W_RAW > 1) ? WAIT_W_RAW : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(BYTE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              tx_start;
    logic              gap_zero;
    logic              can_pop;

    assign can_pop  = en & ~bus.fifo_empty;
    assign tx_start = (state_q == ST_SEND) & ~bus.tx_busy;

    uart_gap_timer #(.W(GAP_W)) u_gap_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tx_start),
        .load_val_i(GAP_LOAD),
        .zero_o    (gap_zero)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: if (can_pop) state_d = ST_READ;
            ST_READ: begin
                wait_d  = WAIT_LOAD;
                state_d = (RD_LATENCY > 1) ? ST_WAIT : ST_LOAD;
            end
            ST_WAIT: begin
                if (wait_q == '0) state_d = ST_LOAD;
                else              wait_d  = wait_q - 1'b1;
            end
            ST_LOAD: begin
                tx_data_d = bus.fifo_dout;
                state_d   = ST_SEND;
            end
            ST_SEND: if (tx_start) state_d = ST_GAP;
            // en is re-sampled only here, so a started byte always finishes its gap
            ST_GAP:  if (gap_zero & ~bus.tx_busy) state_d = can_pop ? ST_READ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (cnt_clr) begin
            byte_cnt_d = tx_start ? CNT_W'(1) : '0;
        end else if (tx_start) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            tx_data_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            tx_data_q  <= tx_data_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign bus.fifo_rd_en = (state_q == ST_READ);
    assign bus.tx_start   = tx_start;
    assign bus.tx_data    = tx_data_q;
    assign byte_cnt       = byte_cnt_q;
    assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fifo_uart_rd_ctrl.sv
// Directed bench for fifo_uart_rd_ctrl: a default-sized instance and a small
// instance (short gap, two-cycle FIFO latency, 4-bit counter) for wrap cases.
module tb_fifo_uart_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, clr_a, busy_a;
    logic [15:0] cnt_a;
    logic        en_b, clr_b, busy_b;
    logic [3:0]  cnt_b;

    fifo_uart_rd_ctrl_if #(.DATA_W(8)) ifa ();
    fifo_uart_rd_ctrl_if #(.DATA_W(8)) ifb ();

    fifo_uart_rd_ctrl #(
        .DATA_W(8), .BYTE_CYCLES(320), .RD_LATENCY(1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .cnt_clr(clr_a),
        .byte_cnt(cnt_a), .busy(busy_a), .bus(ifa)
    );

    fifo_uart_rd_ctrl #(
        .DATA_W(8), .BYTE_CYCLES(4), .RD_LATENCY(2), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .cnt_clr(clr_b),
        .byte_cnt(cnt_b), .busy(busy_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rd_empty_err = 0;
    int a_reads = 0, a_starts = 0, b_reads = 0, b_starts = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] b_stage;
    logic       b_stage_v = 1'b0;

    logic        oa_rd, oa_start, oa_busy;
    logic [7:0]  oa_data;
    logic [15:0] oa_cnt;
    logic        ob_rd, ob_start, ob_busy;
    logic [7:0]  ob_data;
    logic [3:0]  ob_cnt;

    typedef struct {
        logic [7:0]  data;
        int          busy_cyc;
        logic [7:0]  exp_data;
        int          exp_lat;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observe the current cycle, cross one clock edge, then update the FIFO models.
    task automatic step();
        logic ra, rb;
        #1;
        oa_rd = ifa.fifo_rd_en; oa_start = ifa.tx_start; oa_busy = busy_a;
        oa_data = ifa.tx_data;  oa_cnt = cnt_a;
        ob_rd = ifb.fifo_rd_en; ob_start = ifb.tx_start; ob_busy = busy_b;
        ob_data = ifb.tx_data;  ob_cnt = cnt_b;
        if (oa_rd) a_reads++;
        if (oa_start) a_starts++;
        if (ob_rd) b_reads++;
        if (ob_start) b_starts++;
        ra = oa_rd;
        rb = ob_rd;
        @(posedge clk);
        #1;
        if (ra) begin
            if (qa.size() == 0) rd_empty_err++;
            else ifa.fifo_dout = qa.pop_front();
        end
        ifa.fifo_empty = (qa.size() == 0);
        if (b_stage_v) ifb.fifo_dout = b_stage;
        b_stage_v = 1'b0;
        if (rb) begin
            if (qb.size() == 0) rd_empty_err++;
            else begin
                b_stage   = qb.pop_front();
                b_stage_v = 1'b1;
            end
        end
        ifb.fifo_empty = (qb.size() == 0);
    endtask

    task automatic push_a(input logic [7:0] d);
        qa.push_back(d);
        ifa.fifo_empty = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        qb.push_back(d);
        ifb.fifo_empty = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rd, first_st, gap_end, unstable, rd0, st0, nst, nb;
        int st_cyc[3];
        logic [7:0]  st_dat[3];
        logic [7:0]  st_data;
        logic [15:0] end_cnt;
        logic        chk_next;
        int          chk_idx;

        vecs[0] = '{8'hA5, 0,    8'hA5, 3,    16'd1};
        vecs[1] = '{8'h3C, 0,    8'h3C, 3,    16'd2};
        vecs[2] = '{8'h00, 5,    8'h00, 5,    16'd3};
        vecs[3] = '{8'hFF, 1000, 8'hFF, 1000, 16'd4};

        rst = 1'b1;
        en_a = 1'b0; clr_a = 1'b0; en_b = 1'b0; clr_b = 1'b0;
        ifa.fifo_empty = 1'b1; ifa.fifo_dout = 8'h00; ifa.tx_busy = 1'b0;
        ifb.fifo_empty = 1'b1; ifb.fifo_dout = 8'h00; ifb.tx_busy = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset busy",     32'(oa_busy),  32'd0);
        check("reset byte_cnt", 32'(oa_cnt),   32'd0);
        check("reset tx_data",  32'(oa_data),  32'd0);
        check("reset rd_en",    32'(oa_rd),    32'd0);
        check("reset tx_start", 32'(oa_start), 32'd0);

        // single-byte transfers with optional tx_busy hold-off
        for (int v = 0; v < 4; v++) begin
            rd0 = a_reads; first_rd = -1; first_st = -1; gap_end = -1;
            unstable = 0; st_data = 8'h00; end_cnt = 16'h0;
            push_a(vecs[v].data);
            en_a = 1'b1;
            for (int k = 0; k < vecs[v].exp_lat + 400; k++) begin
                ifa.tx_busy = (k < vecs[v].busy_cyc);
                step();
                if (oa_rd && first_rd < 0) first_rd = k;
                if (oa_start && first_st < 0) begin
                    first_st = k;
                    st_data  = oa_data;
                end
                if (first_st < 0 && k >= 3 && oa_data !== vecs[v].exp_data) unstable++;
                if (first_st >= 0 && !oa_busy) begin
                    gap_end = k;
                    end_cnt = oa_cnt;
                    break;
                end
            end
            ifa.tx_busy = 1'b0;
            en_a = 1'b0;
            check($sformatf("vec%0d rd_en cycle", v),    32'(first_rd), 32'd1);
            check($sformatf("vec%0d tx_start cycle", v), 32'(first_st), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d tx_data", v),        32'(st_data),  32'(vecs[v].exp_data));
            check($sformatf("vec%0d data held", v),      32'(unstable), 32'd0);
            check($sformatf("vec%0d busy falls", v),     32'(gap_end - first_st), 32'd321);
            check($sformatf("vec%0d byte_cnt", v),       32'(end_cnt),  32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d pops", v),           32'(a_reads - rd0), 32'd1);
        end

        // three queued bytes go out back to back
        rd0 = a_reads; nst = 0;
        push_a(8'h11); push_a(8'h22); push_a(8'h33);
        en_a = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            step();
            if (oa_start && nst < 3) begin
                st_cyc[nst] = k;
                st_dat[nst] = oa_data;
                nst++;
            end
            if (nst == 3 && !oa_busy) break;
        end
        repeat (20) step();
        check("b2b starts", 32'(nst), 32'd3);
        check("b2b data0",  32'(st_dat[0]), 32'h11);
        check("b2b data1",  32'(st_dat[1]), 32'h22);
        check("b2b data2",  32'(st_dat[2]), 32'h33);
        check("b2b spacing01", 32'(st_cyc[1] - st_cyc[0]), 32'd323);
        check("b2b spacing12", 32'(st_cyc[2] - st_cyc[1]), 32'd323);
        check("b2b byte_cnt",  32'(oa_cnt), 32'd7);
        check("b2b pops",      32'(a_reads - rd0), 32'd3);
        en_a = 1'b0;

        // en dropped during the first gap stops further pops until re-enabled
        rd0 = a_reads; st0 = a_starts;
        push_a(8'h44); push_a(8'h55); push_a(8'h66);
        en_a = 1'b1;
        for (int k = 0; k < 400; k++) begin
            step();
            if (a_starts - st0 == 1) break;
        end
        repeat (10) step();
        en_a = 1'b0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (!oa_busy) break;
        end
        repeat (50) step();
        check("en-low idle",   32'(oa_busy), 32'd0);
        check("en-low pops",   32'(a_reads - rd0), 32'd1);
        check("en-low starts", 32'(a_starts - st0), 32'd1);
        en_a = 1'b1; nst = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (oa_start && nst < 2) begin
                st_dat[nst] = oa_data;
                nst++;
            end
            if (nst == 2 && !oa_busy) break;
        end
        en_a = 1'b0;
        check("resume data1",    32'(st_dat[0]), 32'h55);
        check("resume data2",    32'(st_dat[1]), 32'h66);
        check("resume pops",     32'(a_reads - rd0), 32'd3);
        check("resume byte_cnt", 32'(oa_cnt), 32'd10);

        // reset in the middle of a gap (counter at 100)
        st0 = a_starts;
        push_a(8'h77);
        en_a = 1'b1;
        for (int k = 0; k < 400; k++) begin
            step();
            if (a_starts - st0 == 1) break;
        end
        en_a = 1'b0;
        repeat (219) step();
        rst = 1'b1;
        step();
        check("pre-reset busy", 32'(oa_busy), 32'd1);
        check("pre-reset cnt",  32'(oa_cnt),  32'd11);
        rst = 1'b0;
        step();
        check("gap reset busy",     32'(oa_busy),  32'd0);
        check("gap reset byte_cnt", 32'(oa_cnt),   32'd0);
        check("gap reset tx_data",  32'(oa_data),  32'd0);
        check("gap reset rd_en",    32'(oa_rd),    32'd0);
        check("gap reset tx_start", 32'(oa_start), 32'd0);

        // small instance: 17 bytes, counter wrap, clear coinciding with a start
        rd0 = b_reads; nb = 0; chk_next = 1'b0; chk_idx = 0;
        for (int i = 0; i < 17; i++) push_b(8'(i * 7 + 3));
        en_b = 1'b1;
        for (int k = 0; k < 200; k++) begin
            clr_b = (k == 4 + 8 * 16);
            step();
            if (chk_next) begin
                chk_next = 1'b0;
                if (chk_idx == 14) check("wrap cnt 15",  32'(ob_cnt), 32'd15);
                if (chk_idx == 15) check("wrap cnt 0",   32'(ob_cnt), 32'd0);
                if (chk_idx == 16) check("clr+start cnt", 32'(ob_cnt), 32'd1);
            end
            if (ob_start) begin
                check($sformatf("b start%0d cycle", nb), 32'(k), 32'(4 + 8 * nb));
                check($sformatf("b start%0d data", nb),  32'(ob_data), 32'(nb * 7 + 3));
                chk_next = 1'b1;
                chk_idx  = nb;
                nb++;
            end
        end
        clr_b = 1'b0;
        en_b  = 1'b0;
        check("b starts", 32'(nb), 32'd17);
        check("b pops",   32'(b_reads - rd0), 32'd17);
        check("b idle",   32'(ob_busy), 32'd0);
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        step();
        check("b clr alone", 32'(ob_cnt), 32'd0);

        check("reads while empty", 32'(rd_empty_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
